// File: rtl/gsim_pkg.sv
// Shared sizes, band coefficients, FSM encoding and a shift-add constant
// multiplier for the GSIM residual checker.
package gsim_pkg;

    localparam int N   = 16;   // rows per problem
    localparam int XW  = 32;   // x word, signed Q16.16
    localparam int RW  = 40;   // residual / accumulator, signed Q24.16
    localparam int BW  = 16;   // b word, signed integer
    localparam int QSH = 16;   // Q16.16 fractional bits

    // Band magnitudes; the signs (+diag, -1st, +2nd, -3rd) are applied at the adder tree
    localparam int C_D = 20;
    localparam int C_1 = 13;
    localparam int C_2 = 6;
    localparam int C_3 = 1;

    localparam logic [RW-1:0] TOL = 40'd655;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CHECK   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Multiply by a small non-negative constant using only shifts and adds
    function automatic logic signed [RW-1:0] cmul(input logic signed [RW-1:0] v, input int c);
        logic signed [RW-1:0] acc;
        acc = '0;
        for (int b = 0; b < 8; b++) begin
            if (c[b]) acc = acc + (v <<< b);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gsim_row_residual.sv
// Combinational residual for one row: r = (b << 16) - A*x over the 7-tap band.
// Taps arrive pre-zeroed for out-of-range neighbours; index 3 is the diagonal.
module gsim_row_residual
    import gsim_pkg::*;
(
    input  logic [BW-1:0]         i_b,
    input  logic [6:0][XW-1:0]    i_tap,
    output logic signed [RW-1:0]  o_res,
    output logic [RW-1:0]         o_abs
);

    logic signed [RW-1:0] w_t [7];
    logic signed [RW-1:0] w_s1, w_s2, w_s3, w_ax, w_bq;

    // Sign-extend every tap to the accumulator width before any arithmetic
    always_comb begin
        for (int k = 0; k < 7; k++) begin
            w_t[k] = RW'($signed(i_tap[k]));
        end
    end

    // Symmetric band: pair the neighbours first so each coefficient is applied once
    assign w_s1 = w_t[2] + w_t[4];
    assign w_s2 = w_t[1] + w_t[5];
    assign w_s3 = w_t[0] + w_t[6];
    assign w_ax = cmul(w_t[3], C_D) - cmul(w_s1, C_1) + cmul(w_s2, C_2) - cmul(w_s3, C_3);
    assign w_bq = RW'($signed(i_b)) <<< QSH;

    assign o_res = w_bq - w_ax;
    assign o_abs = o_res[RW-1] ? RW'(-o_res) : RW'(o_res);

endmodule

// File: rtl/gsim_residual_checker.sv
// Snoops b and x streams of the GSIM solver and streams exact per-row residuals
// plus a per-problem summary. b is double-buffered so the next problem can load
// while the current one is being checked.
module gsim_residual_checker
    import gsim_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_b_en,
    input  logic [BW-1:0]        i_b_in,
    input  logic                 i_x_valid,
    input  logic [XW-1:0]        i_x_in,
    output logic                 o_res_valid,
    output logic [3:0]           o_res_idx,
    output logic [RW-1:0]        o_res_out,
    output logic                 o_res_pass,
    output logic                 o_done,
    output logic                 o_all_pass,
    output logic [RW-1:0]        o_max_abs,
    output logic                 o_ovf
);

    logic [BW-1:0]  r_bank [2][N];
    logic [1:0]     r_b_full;
    logic           r_ld_sel, r_chk_sel;
    logic [3:0]     r_b_cnt;
    logic [XW-1:0]  r_x [N];
    logic [4:0]     r_x_cnt;
    state_t         r_state, w_next;
    logic [3:0]     r_row;
    logic [RW-1:0]  r_run_max;
    logic           r_run_pass;

    logic                 w_b_wr, w_b_drop, w_x_acc, w_x_drop, w_pass;
    logic [6:0][XW-1:0]   w_tap;
    logic signed [RW-1:0] w_res;
    logic [RW-1:0]        w_abs;

    // Full flags are the registered ones: a bank freed this cycle cannot take this word
    assign w_b_wr   = i_b_en && !r_b_full[r_ld_sel];
    assign w_b_drop = i_b_en &&  r_b_full[r_ld_sel];
    assign w_x_acc  = i_x_valid && (r_state == ST_COLLECT) && (r_x_cnt < 5'(N));
    assign w_x_drop = i_x_valid && !w_x_acc;

    // b bank storage (data only, no reset needed)
    always_ff @(posedge i_clk) begin
        if (w_b_wr) r_bank[r_ld_sel][r_b_cnt] <= i_b_in;
    end

    // b load pointer and bank ownership; DONE releases the bank just checked
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_b_full <= '0;
            r_ld_sel <= 1'b0;
            r_b_cnt  <= '0;
        end else begin
            if (w_b_wr) begin
                if (r_b_cnt == 4'(N-1)) begin
                    r_b_full[r_ld_sel] <= 1'b1;
                    r_ld_sel           <= ~r_ld_sel;
                    r_b_cnt            <= '0;
                end else begin
                    r_b_cnt <= r_b_cnt + 4'd1;
                end
            end
            if (r_state == ST_DONE) r_b_full[r_chk_sel] <= 1'b0;
        end
    end

    // x storage (data only)
    always_ff @(posedge i_clk) begin
        if (w_x_acc) r_x[r_x_cnt[3:0]] <= i_x_in;
    end

    // x word counter; restarts once the problem has been summarised
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                r_x_cnt <= '0;
        else if (r_state == ST_DONE) r_x_cnt <= '0;
        else if (w_x_acc)            r_x_cnt <= r_x_cnt + 5'd1;
    end

    // Gather the 7 band taps around the current row, zeroing off-matrix neighbours
    always_comb begin
        int j;
        j     = 0;
        w_tap = '0;
        for (int k = 0; k < 7; k++) begin
            j = int'(r_row) + k - 3;
            if (j >= 0 && j < N) w_tap[k] = r_x[j[3:0]];
        end
    end

    gsim_row_residual u_row (
        .i_b   (r_bank[r_chk_sel][r_row]),
        .i_tap (w_tap),
        .o_res (w_res),
        .o_abs (w_abs)
    );

    assign w_pass = (w_abs <= TOL);

    // Next-state: wait for a complete x set and a full b bank, sweep 16 rows, summarise
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_COLLECT: if (r_x_cnt == 5'(N) && r_b_full[r_chk_sel]) w_next = ST_CHECK;
            ST_CHECK:   if (r_row == 4'(N-1)) w_next = ST_DONE;
            ST_DONE:    w_next = ST_COLLECT;
            default:    w_next = ST_COLLECT;
        endcase
    end

    // State, row counter and running summary accumulators
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_COLLECT;
            r_row      <= '0;
            r_chk_sel  <= 1'b0;
            r_run_max  <= '0;
            r_run_pass <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_COLLECT && w_next == ST_CHECK) begin
                r_row      <= '0;
                r_run_max  <= '0;
                r_run_pass <= 1'b1;
            end
            if (r_state == ST_CHECK) begin
                r_row <= r_row + 4'd1;
                if (w_abs > r_run_max) r_run_max <= w_abs;
                if (!w_pass)           r_run_pass <= 1'b0;
            end
            if (r_state == ST_DONE) r_chk_sel <= ~r_chk_sel;
        end
    end

    // Registered outputs: row results one cycle after their CHECK cycle, summary after DONE
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_res_valid <= 1'b0;
            o_res_idx   <= '0;
            o_res_out   <= '0;
            o_res_pass  <= 1'b0;
            o_done      <= 1'b0;
            o_all_pass  <= 1'b0;
            o_max_abs   <= '0;
            o_ovf       <= 1'b0;
        end else begin
            o_res_valid <= (r_state == ST_CHECK);
            o_done      <= (r_state == ST_DONE);
            o_ovf       <= o_ovf | w_b_drop | w_x_drop;
            if (r_state == ST_CHECK) begin
                o_res_idx  <= r_row;
                o_res_out  <= w_res;
                o_res_pass <= w_pass;
            end
            if (r_state == ST_DONE) begin
                o_all_pass <= r_run_pass;
                o_max_abs  <= r_run_max;
            end
        end
    end

endmodule

// File: tb/tb_gsim_residual_checker.sv
// Scoreboard bench: expected rows/summaries are computed from a reference
// band model when stimulus is driven and compared as the checker emits them.
module tb_gsim_residual_checker;

    typedef logic signed [15:0] bvec_t [16];
    typedef logic signed [31:0] xvec_t [16];
    typedef struct { logic [3:0] idx; logic [39:0] res; logic pass; } row_t;
    typedef struct { logic ap; logic [39:0] mx; } sum_t;

    logic        i_clk = 1'b0, i_rst_n = 1'b0;
    logic        i_b_en = 1'b0, i_x_valid = 1'b0;
    logic [15:0] i_b_in = '0;
    logic [31:0] i_x_in = '0;
    logic        o_res_valid, o_res_pass, o_done, o_all_pass, o_ovf;
    logic [3:0]  o_res_idx;
    logic [39:0] o_res_out, o_max_abs;

    int n_chk = 0, n_fail = 0, done_cnt = 0;
    bit prev_r15 = 1'b0;
    row_t q_row[$];
    sum_t q_sum[$];

    always #5 i_clk = ~i_clk;

    gsim_residual_checker dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_b_en(i_b_en), .i_b_in(i_b_in),
        .i_x_valid(i_x_valid), .i_x_in(i_x_in), .o_res_valid(o_res_valid),
        .o_res_idx(o_res_idx), .o_res_out(o_res_out), .o_res_pass(o_res_pass),
        .o_done(o_done), .o_all_pass(o_all_pass), .o_max_abs(o_max_abs), .o_ovf(o_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Reference: direct band product with ordinary multiplies in 64-bit
    function automatic logic [39:0] model_r(input bvec_t b, input xvec_t x, input int i);
        longint acc;
        int c [7] = '{-1, 6, -13, 20, -13, 6, -1};
        acc = longint'(b[i]) * 65536;
        for (int k = 0; k < 7; k++) begin
            if (i + k - 3 >= 0 && i + k - 3 < 16) acc -= longint'(c[k]) * longint'(x[i+k-3]);
        end
        return acc[39:0];
    endfunction

    task automatic push_expect(input bvec_t b, input xvec_t x);
        row_t r;
        sum_t s;
        logic [39:0] a;
        s.ap = 1'b1;
        s.mx = '0;
        for (int i = 0; i < 16; i++) begin
            r.idx  = 4'(i);
            r.res  = model_r(b, x, i);
            a      = r.res[39] ? -r.res : r.res;
            r.pass = (a <= 40'd655);
            if (!r.pass) s.ap = 1'b0;
            if (a > s.mx) s.mx = a;
            q_row.push_back(r);
        end
        q_sum.push_back(s);
    endtask

    task automatic send_b(input bvec_t b);
        for (int i = 0; i < 16; i++) begin
            i_b_en = 1'b1;
            i_b_in = b[i];
            tick();
        end
        i_b_en = 1'b0;
    endtask

    task automatic send_x(input xvec_t x);
        for (int i = 0; i < 16; i++) begin
            i_x_valid = 1'b1;
            i_x_in    = x[i];
            tick();
        end
        i_x_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 400 && done_cnt < target; c++) tick();
        chk("done_wait", 64'(done_cnt >= target), 64'd1);
    endtask

    // Output monitor: pops the scoreboard on every row result and summary
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_res_valid) begin
                if (q_row.size() == 0) begin
                    chk("row_unexpected", 64'd1, 64'd0);
                end else begin
                    row_t e;
                    e = q_row.pop_front();
                    chk("res_idx", 64'(o_res_idx), 64'(e.idx));
                    chk("res_out", 64'(o_res_out), 64'(e.res));
                    chk("res_pass", 64'(o_res_pass), 64'(e.pass));
                end
            end
            if (o_done) begin
                chk("done_lat", 64'(prev_r15), 64'd1);
                if (q_sum.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    sum_t s;
                    s = q_sum.pop_front();
                    chk("all_pass", 64'(o_all_pass), 64'(s.ap));
                    chk("max_abs", 64'(o_max_abs), 64'(s.mx));
                end
                done_cnt++;
            end
            prev_r15 = o_res_valid && (o_res_idx == 4'd15);
        end
    end

    initial begin
        bvec_t bz, b2, b3, bA, bB, bP, bQ, bR, bS;
        xvec_t xz, x2, xA, xB, xP, xQ, xR, xS;
        int d0;
        bit hit;

        for (int i = 0; i < 16; i++) begin
            bz[i] = '0;  xz[i] = '0;
            b2[i] = (i == 0) ? 16'sd20 : 16'sd0;
            x2[i] = (i == 0) ? 32'sh0001_0000 : 32'sd0;
            b3[i] = 16'(i);
            bA[i] = 16'($urandom_range(0, 400)) - 16'sd200;
            xA[i] = 32'($urandom_range(0, 32'h0020_0000)) - 32'sh0010_0000;
            bB[i] = 16'(3 * i - 20);
            xB[i] = 32'sh0000_8000 * (i - 8);
            bP[i] = 16'sd7;      xP[i] = 32'sh0000_4000;
            bQ[i] = -16'sd5;     xQ[i] = -32'sh0001_0000;
            bR[i] = 16'(i * i);  xR[i] = 32'(i) <<< 12;
            bS[i] = 16'sd1;      xS[i] = 32'sh0000_1000;
        end

        // Reset state
        repeat (3) tick();
        chk("rst_res_valid", 64'(o_res_valid), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_ovf", 64'(o_ovf), 64'd0);
        chk("rst_all_pass", 64'(o_all_pass), 64'd0);
        chk("rst_max_abs", 64'(o_max_abs), 64'd0);
        i_rst_n = 1'b1;
        tick();

        // All-zero problem, single impulse, b ramp
        send_b(bz); push_expect(bz, xz); send_x(xz); wait_done(1);
        send_b(b2); push_expect(b2, x2); send_x(x2); wait_done(2);
        send_b(b3); push_expect(b3, xz); send_x(xz); wait_done(3);

        // Load B into the other bank while A is being checked
        send_b(bA); push_expect(bA, xA); send_x(xA);
        send_b(bB);
        chk("ovf_dbl_buf", 64'(o_ovf), 64'd0);
        wait_done(4);
        push_expect(bB, xB); send_x(xB); wait_done(5);

        // Both banks full, 33rd b word dropped
        send_b(bP); send_b(bQ);
        chk("ovf_before_b33", 64'(o_ovf), 64'd0);
        i_b_en = 1'b1; i_b_in = 16'h7fff; tick(); i_b_en = 1'b0;
        chk("ovf_b33", 64'(o_ovf), 64'd1);
        push_expect(bP, xP); send_x(xP); wait_done(6);
        push_expect(bQ, xQ); send_x(xQ); wait_done(7);

        // 17th x word dropped; results use the first 16
        i_rst_n = 1'b0; tick(); i_rst_n = 1'b1;
        chk("ovf_after_rst", 64'(o_ovf), 64'd0);
        push_expect(bR, xR); send_x(xR);
        chk("ovf_before_x17", 64'(o_ovf), 64'd0);
        i_x_valid = 1'b1; i_x_in = 32'h7fff_ffff; tick(); i_x_valid = 1'b0;
        chk("ovf_x17", 64'(o_ovf), 64'd1);
        send_b(bR); wait_done(8);

        // Reset during CHECK row 7 aborts the problem
        send_b(bS); push_expect(bS, xS); send_x(xS);
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge i_clk);
            if (o_res_valid && o_res_idx == 4'd6) hit = 1'b1;
        end
        chk("row6_seen", 64'(hit), 64'd1);
        #1;
        q_row.delete(); q_sum.delete();
        i_rst_n = 1'b0;
        tick();
        chk("abort_res_valid", 64'(o_res_valid), 64'd0);
        chk("abort_res_out", 64'(o_res_out), 64'd0);
        chk("abort_max_abs", 64'(o_max_abs), 64'd0);
        chk("abort_ovf", 64'(o_ovf), 64'd0);
        i_rst_n = 1'b1;
        d0 = done_cnt;
        repeat (30) tick();
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        chk("abort_no_rows", 64'(o_res_valid), 64'd0);

        // Fresh problem after abort
        send_b(b3); push_expect(b3, xz); send_x(xz); wait_done(d0 + 1);

        repeat (3) tick();
        chk("rows_drained", 64'(q_row.size()), 64'd0);
        chk("sums_drained", 64'(q_sum.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
